// File: rtl/tile_lane_shifter.sv
// rtl/tile_lane_shifter.sv - piano-tiles row shifter with hit judging, score/miss counters and game-over freeze
// Optional feature macro: TILE_NO_REPEAT_EN (inserted lane never repeats the current top row lane)
module tile_lane_shifter #(
    parameter int          LANES    = 4,
    parameter int          DEPTH    = 7,
    parameter logic [7:0]  SEED     = 8'h01,
    parameter int          MAX_MISS = 3,
    localparam int         LW       = $clog2(LANES + 1)
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                shift,
    input  logic                hit_valid,
    input  logic [LW-1:0]       hit_lane,
    output logic [DEPTH*LW-1:0] rows,
    output logic                hit_ok,
    output logic                hit_bad,
    output logic                miss,
    output logic [15:0]         score,
    output logic [7:0]          misses,
    output logic                game_over
);
    typedef enum logic {ST_RUN, ST_OVER} state_t;

    localparam logic [7:0]    SEED_EFF   = (SEED == 8'h00) ? 8'h01 : SEED;
    localparam logic [8:0]    MAX_MISS_W = 9'(MAX_MISS);
    localparam logic [LW-1:0] LANES_W    = LW'(LANES);

    state_t               r_state;
    logic [7:0]           r_lfsr;
    logic [DEPTH*LW-1:0]  r_rows;
    logic [15:0]          r_score;
    logic [7:0]           r_misses;
    logic                 r_hit_ok;
    logic                 r_hit_bad;
    logic                 r_miss;
    logic                 r_game_over;

    logic [LW-1:0]        w_bottom;
    logic [LW-1:0]        w_cand;
    logic [LW-1:0]        w_ins;
    logic                 w_hit_good;
    logic                 w_hit_bad;
    logic                 w_fall;
    logic [8:0]           w_miss_sum;
    logic [7:0]           w_misses_next;
    logic                 w_over_next;
    logic [7:0]           w_lfsr_next;
    logic [DEPTH*LW-1:0]  w_rows_clr;
    logic [DEPTH*LW-1:0]  w_rows_next;

    assign w_bottom    = r_rows[(DEPTH-1)*LW +: LW];
    assign w_lfsr_next = {r_lfsr[6:0], r_lfsr[7] ^ r_lfsr[5] ^ r_lfsr[4] ^ r_lfsr[3]};
    assign w_cand      = LW'(r_lfsr % 8'(LANES)) + LW'(1);

`ifdef TILE_NO_REPEAT_EN
    logic [LW-1:0] w_row0;
    assign w_row0 = r_rows[LW-1:0];
    // Bump to the next lane (wrapping LANES -> 1) when the candidate repeats the top row
    assign w_ins  = (w_row0 != '0 && w_cand == w_row0)
                  ? ((w_cand == LANES_W) ? LW'(1) : w_cand + LW'(1))
                  : w_cand;
`else
    assign w_ins  = w_cand;
`endif

    assign w_hit_good    = hit_valid && (w_bottom != '0) && (hit_lane == w_bottom);
    assign w_hit_bad     = hit_valid && !w_hit_good;
    assign w_fall        = shift && (w_bottom != '0) && !w_hit_good;
    assign w_miss_sum    = {1'b0, r_misses} + 9'(w_hit_bad) + 9'(w_fall);
    assign w_over_next   = (w_miss_sum >= MAX_MISS_W);
    assign w_misses_next = w_over_next ? MAX_MISS_W[7:0] : w_miss_sum[7:0];

    // A correct hit clears the bottom before the shift so the tile cannot also count as a fall-off
    always_comb begin
        w_rows_clr = r_rows;
        if (w_hit_good)
            w_rows_clr[(DEPTH-1)*LW +: LW] = '0;
        w_rows_next = shift ? {w_rows_clr[(DEPTH-1)*LW-1:0], w_ins} : w_rows_clr;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state     <= ST_RUN;
            r_lfsr      <= SEED_EFF;
            r_rows      <= '0;
            r_score     <= '0;
            r_misses    <= '0;
            r_hit_ok    <= 1'b0;
            r_hit_bad   <= 1'b0;
            r_miss      <= 1'b0;
            r_game_over <= 1'b0;
        end else begin
            r_lfsr    <= w_lfsr_next;
            r_hit_ok  <= 1'b0;
            r_hit_bad <= 1'b0;
            r_miss    <= 1'b0;
            case (r_state)
                ST_RUN: begin
                    r_rows    <= w_rows_next;
                    r_hit_ok  <= w_hit_good;
                    r_hit_bad <= w_hit_bad;
                    r_miss    <= w_fall;
                    r_misses  <= w_misses_next;
                    if (w_hit_good && r_score != 16'hFFFF)
                        r_score <= r_score + 16'd1;
                    if (w_over_next) begin
                        r_state     <= ST_OVER;
                        r_game_over <= 1'b1;
                    end
                end
                ST_OVER: begin
                    r_game_over <= 1'b1;
                end
                default: r_state <= ST_RUN;
            endcase
        end
    end

    assign rows      = r_rows;
    assign hit_ok    = r_hit_ok;
    assign hit_bad   = r_hit_bad;
    assign miss      = r_miss;
    assign score     = r_score;
    assign misses    = r_misses;
    assign game_over = r_game_over;
endmodule

// File: tb/tb_tile_lane_shifter.sv
// tb/tb_tile_lane_shifter.sv - directed self-checking bench for tile_lane_shifter
module tb_tile_lane_shifter;
    localparam int LANES    = 4;
    localparam int DEPTH    = 7;
    localparam int LW       = 3;
    localparam int MAX_MISS = 3;

    logic                clk = 1'b0;
    logic                reset = 1'b1;
    logic                shift = 1'b0;
    logic                hit_valid = 1'b0;
    logic [LW-1:0]       hit_lane = '0;
    logic [DEPTH*LW-1:0] rows;
    logic                hit_ok;
    logic                hit_bad;
    logic                miss;
    logic [15:0]         score;
    logic [7:0]          misses;
    logic                game_over;

    int n_tests = 0;
    int n_fail  = 0;
    int ins_seq [8];

    always #5 clk = ~clk;

    tile_lane_shifter #(
        .LANES(LANES), .DEPTH(DEPTH), .SEED(8'h01), .MAX_MISS(MAX_MISS)
    ) dut (
        .clk(clk), .reset(reset), .shift(shift), .hit_valid(hit_valid), .hit_lane(hit_lane),
        .rows(rows), .hit_ok(hit_ok), .hit_bad(hit_bad), .miss(miss),
        .score(score), .misses(misses), .game_over(game_over)
    );

    function automatic logic [LW-1:0] row_at(input int k);
        return rows[k*LW +: LW];
    endfunction

    function automatic logic [DEPTH*LW-1:0] rows_after7();
        logic [DEPTH*LW-1:0] v;
        for (int k = 0; k < DEPTH; k++)
            v[k*LW +: LW] = LW'(ins_seq[6-k]);
        return v;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        reset = 1'b1; shift = 1'b0; hit_valid = 1'b0; hit_lane = '0;
        tick();
        reset = 1'b0;
    endtask

    task automatic shift_n(input int n);
        shift = 1'b1;
        repeat (n) tick();
        shift = 1'b0;
    endtask

    task automatic test_reset();
        do_reset();
        shift_n(3);
        reset = 1'b1; shift = 1'b1; hit_valid = 1'b1; hit_lane = 3'd1;
        tick();
        n_tests++; if (rows !== '0) begin n_fail++; $display("FAIL reset_rows got=%h exp=0", rows); end
        n_tests++; if ({hit_ok, hit_bad, miss} !== 3'b000) begin n_fail++; $display("FAIL reset_pulses got=%b exp=000", {hit_ok, hit_bad, miss}); end
        n_tests++; if (score !== 16'd0 || misses !== 8'd0) begin n_fail++; $display("FAIL reset_counters score=%0d misses=%0d exp=0,0", score, misses); end
        n_tests++; if (game_over !== 1'b0) begin n_fail++; $display("FAIL reset_game_over got=%b exp=0", game_over); end
        reset = 1'b0; shift = 1'b0; hit_valid = 1'b0;
    endtask

    task automatic test_sequence_fill();
        do_reset();
        shift = 1'b1;
        for (int i = 0; i < 7; i++) begin
            tick();
            n_tests++; if (row_at(0) !== LW'(ins_seq[i])) begin n_fail++; $display("FAIL seq_row0[%0d] got=%0d exp=%0d", i, row_at(0), ins_seq[i]); end
            n_tests++; if (miss !== 1'b0) begin n_fail++; $display("FAIL fill_no_miss[%0d] got=%b exp=0", i, miss); end
        end
        n_tests++; if (rows !== rows_after7()) begin n_fail++; $display("FAIL fill_rows got=%h exp=%h", rows, rows_after7()); end
        tick();
        shift = 1'b0;
        n_tests++; if (miss !== 1'b1 || misses !== 8'd1) begin n_fail++; $display("FAIL fall_off miss=%b misses=%0d exp=1,1", miss, misses); end
        n_tests++; if (row_at(6) !== LW'(ins_seq[1]) || row_at(0) !== LW'(ins_seq[7])) begin n_fail++; $display("FAIL fall_off_rows row6=%0d row0=%0d exp=%0d,%0d", row_at(6), row_at(0), ins_seq[1], ins_seq[7]); end
        tick();
        n_tests++; if (miss !== 1'b0) begin n_fail++; $display("FAIL miss_one_cycle got=%b exp=0", miss); end
    endtask

    task automatic test_correct_hit();
        do_reset();
        shift_n(7);
        hit_valid = 1'b1; hit_lane = 3'd2;
        tick();
        hit_valid = 1'b0;
        n_tests++; if (hit_ok !== 1'b1 || hit_bad !== 1'b0) begin n_fail++; $display("FAIL hit_ok ok=%b bad=%b exp=1,0", hit_ok, hit_bad); end
        n_tests++; if (score !== 16'd1 || row_at(6) !== 3'd0) begin n_fail++; $display("FAIL hit_score score=%0d row6=%0d exp=1,0", score, row_at(6)); end
        shift_n(1);
        n_tests++; if (miss !== 1'b0 || hit_ok !== 1'b0 || misses !== 8'd0) begin n_fail++; $display("FAIL hit_then_shift miss=%b ok=%b misses=%0d exp=0,0,0", miss, hit_ok, misses); end
        n_tests++; if (row_at(6) !== LW'(ins_seq[1]) || score !== 16'd1) begin n_fail++; $display("FAIL hit_then_shift_rows row6=%0d score=%0d exp=%0d,1", row_at(6), score, ins_seq[1]); end
    endtask

    task automatic test_wrong_hit();
        do_reset();
        hit_valid = 1'b1; hit_lane = 3'd1;
        tick();
        hit_valid = 1'b0;
        n_tests++; if (hit_bad !== 1'b1 || hit_ok !== 1'b0 || misses !== 8'd1) begin n_fail++; $display("FAIL empty_hit bad=%b ok=%b misses=%0d exp=1,0,1", hit_bad, hit_ok, misses); end
        do_reset();
        shift_n(7);
        hit_valid = 1'b1; hit_lane = 3'd3;
        tick();
        n_tests++; if (hit_bad !== 1'b1 || misses !== 8'd1 || row_at(6) !== 3'd2) begin n_fail++; $display("FAIL wrong_hit bad=%b misses=%0d row6=%0d exp=1,1,2", hit_bad, misses, row_at(6)); end
        hit_lane = 3'd0;
        tick();
        hit_valid = 1'b0;
        n_tests++; if (hit_bad !== 1'b1 || misses !== 8'd2 || score !== 16'd0) begin n_fail++; $display("FAIL lane0_hit bad=%b misses=%0d score=%0d exp=1,2,0", hit_bad, misses, score); end
    endtask

    task automatic test_same_cycle();
        do_reset();
        shift_n(7);
        shift = 1'b1; hit_valid = 1'b1; hit_lane = 3'd2;
        tick();
        n_tests++; if (hit_ok !== 1'b1 || miss !== 1'b0 || score !== 16'd1) begin n_fail++; $display("FAIL hit_shift ok=%b miss=%b score=%0d exp=1,0,1", hit_ok, miss, score); end
        n_tests++; if (row_at(6) !== LW'(ins_seq[1])) begin n_fail++; $display("FAIL hit_shift_row6 got=%0d exp=%0d", row_at(6), ins_seq[1]); end
        hit_lane = 3'd1;
        tick();
        shift = 1'b0; hit_valid = 1'b0;
        n_tests++; if (hit_bad !== 1'b1 || miss !== 1'b1 || misses !== 8'd2) begin n_fail++; $display("FAIL bad_and_fall bad=%b miss=%b misses=%0d exp=1,1,2", hit_bad, miss, misses); end
        n_tests++; if (game_over !== 1'b0 || row_at(6) !== LW'(ins_seq[2])) begin n_fail++; $display("FAIL bad_and_fall_state go=%b row6=%0d exp=0,%0d", game_over, row_at(6), ins_seq[2]); end
    endtask

    task automatic test_game_over();
        do_reset();
        shift_n(7);
        hit_valid = 1'b1; hit_lane = 3'd3;
        for (int i = 1; i <= 3; i++) begin
            tick();
            n_tests++; if (misses !== 8'(i) || game_over !== (i == 3)) begin n_fail++; $display("FAIL over_step[%0d] misses=%0d go=%b exp=%0d,%0d", i, misses, game_over, i, (i == 3)); end
        end
        n_tests++; if (hit_bad !== 1'b1) begin n_fail++; $display("FAIL over_final_pulse got=%b exp=1", hit_bad); end
        shift = 1'b1; hit_lane = 3'd2;
        for (int i = 0; i < 3; i++) begin
            tick();
            n_tests++; if ({hit_ok, hit_bad, miss} !== 3'b000) begin n_fail++; $display("FAIL frozen_pulses[%0d] got=%b exp=000", i, {hit_ok, hit_bad, miss}); end
            n_tests++; if (rows !== rows_after7() || misses !== 8'd3 || score !== 16'd0 || game_over !== 1'b1) begin n_fail++; $display("FAIL frozen_state[%0d] rows=%h misses=%0d score=%0d go=%b", i, rows, misses, score, game_over); end
        end
        shift = 1'b0; hit_valid = 1'b0;

        do_reset();
        shift_n(7);
        hit_valid = 1'b1; hit_lane = 3'd3;
        repeat (2) tick();
        shift = 1'b1;
        tick();
        n_tests++; if (misses !== 8'd3 || miss !== 1'b1 || hit_bad !== 1'b1 || game_over !== 1'b1) begin n_fail++; $display("FAIL saturate misses=%0d miss=%b bad=%b go=%b exp=3,1,1,1", misses, miss, hit_bad, game_over); end

        reset = 1'b1;
        tick();
        n_tests++; if (rows !== '0 || score !== 16'd0 || misses !== 8'd0 || game_over !== 1'b0 || {hit_ok, hit_bad, miss} !== 3'b000) begin n_fail++; $display("FAIL over_reset rows=%h misses=%0d go=%b pulses=%b", rows, misses, game_over, {hit_ok, hit_bad, miss}); end
        reset = 1'b0; hit_valid = 1'b0; shift = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            n_tests++; if (row_at(0) !== LW'(ins_seq[i])) begin n_fail++; $display("FAIL restart_row0[%0d] got=%0d exp=%0d", i, row_at(0), ins_seq[i]); end
        end
        shift = 1'b0;
    endtask

    initial begin
`ifdef TILE_NO_REPEAT_EN
        ins_seq = '{2, 3, 1, 2, 3, 4, 1, 3};
`else
        ins_seq = '{2, 3, 1, 1, 2, 4, 4, 3};
`endif
        test_reset();
        test_sequence_fill();
        test_correct_hit();
        test_wrong_hit();
        test_same_cycle();
        test_game_over();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog timeout tests=%0d", n_tests);
        $fatal(1, "watchdog");
    end
endmodule
